// File: rtl/ripple_carry_adder_4_if.sv
// ripple_carry_adder_4_if: operand/result bundle for the 4-bit registered ripple adder
// master drives a, b, cin, in_valid and reads the registered results
// slave reads the operands and drives sum, cout, carry, overflow, out_valid
interface ripple_carry_adder_4_if;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       in_valid;
    logic [3:0] sum;
    logic       cout;
    logic [3:0] carry;
    logic       overflow;
    logic       out_valid;

    modport master (
        output a, b, cin, in_valid,
        input  sum, cout, carry, overflow, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid,
        output sum, cout, carry, overflow, out_valid
    );
endinterface

// File: rtl/ripple_carry_adder_4.sv
// ripple_carry_adder_4: registered 4-bit ripple-carry adder with visible carry chain
// clk, rst: rising-edge clock, synchronous active-high reset
// bus.a, bus.b, bus.cin, bus.in_valid: operands, carry-in and their qualifier
// bus.sum, bus.cout, bus.carry, bus.overflow, bus.out_valid: results, one cycle later
module ripple_carry_adder_4 (
    input logic                    clk,
    input logic                    rst,
    ripple_carry_adder_4_if.slave  bus
);
    logic [3:0] s;
    logic [4:0] c;

    // c[0] is the carry-in; c[i+1] is the carry out of stage i
    assign c[0] = bus.cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        logic p;
        assign p      = bus.a[i] ^ bus.b[i];
        assign s[i]   = p ^ c[i];
        assign c[i+1] = (bus.a[i] & bus.b[i]) | (c[i] & p);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sum       <= 4'b0000;
            bus.cout      <= 1'b0;
            bus.carry     <= 4'b0000;
            bus.overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum      <= s;
                bus.cout     <= c[4];
                bus.carry    <= c[4:1];
                bus.overflow <= c[4] ^ c[3];
            end
        end
    end
endmodule

// File: tb/tb_ripple_carry_adder_4.sv
// tb_ripple_carry_adder_4: directed and exhaustive checks of the registered ripple adder
module tb_ripple_carry_adder_4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails = 0;

    always #5 clk = ~clk;

    ripple_carry_adder_4_if bus ();

    ripple_carry_adder_4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // packed result: {out_valid, overflow, cout, carry[3:0], sum[3:0]}
    function automatic logic [10:0] model(input logic [3:0] a, input logic [3:0] b, input logic ci);
        int         t;
        int         sa;
        int         sb;
        int         ss;
        int         part;
        logic [3:0] cr;
        t  = int'(a) + int'(b) + int'(ci);
        for (int k = 0; k < 4; k++) begin
            part  = (int'(a) % (1 << (k + 1))) + (int'(b) % (1 << (k + 1))) + int'(ci);
            cr[k] = (part >= (1 << (k + 1)));
        end
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        ss = sa + sb + int'(ci);
        return {1'b1, (ss > 7 || ss < -8), t >= 16, cr, 4'(t % 16)};
    endfunction

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic v);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        bus.in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [10:0] exp);
        logic [10:0] got;
        got = {bus.out_valid, bus.overflow, bus.cout, bus.carry, bus.sum};
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s got=%b expected=%b (ov_valid,ovf,cout,carry,sum)", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("reset", 11'b0_0_0_0000_0000);
        rst = 1'b0;
        step(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("zero", 11'b1_0_0_0000_0000);
        step(4'b0011, 4'b0001, 1'b0, 1'b1);
        check("3+1", 11'b1_0_0_0011_0100);
        step(4'b1010, 4'b0101, 1'b1, 1'b1);
        check("a+5+1", 11'b1_0_1_1111_0000);
        step(4'b1111, 4'b1111, 1'b0, 1'b1);
        check("f+f", 11'b1_0_1_1111_1110);
        step(4'b1111, 4'b1111, 1'b1, 1'b1);
        check("f+f+1", 11'b1_0_1_1111_1111);
        step(4'b0111, 4'b0001, 1'b0, 1'b1);
        check("7+1 ovf", 11'b1_1_0_0111_1000);
        step(4'bxxxx, 4'bxxxx, 1'bx, 1'b0);
        check("hold x", 11'b0_1_0_0111_1000);
        step(4'b0001, 4'b0001, 1'b0, 1'b0);
        check("hold", 11'b0_1_0_0111_1000);
        step(4'b1000, 4'b1000, 1'b0, 1'b1);
        check("8+8 ovf", 11'b1_1_1_1000_0000);
        rst = 1'b1;
        step(4'b1111, 4'b1111, 1'b0, 1'b1);
        check("rst over valid", 11'b0_0_0_0000_0000);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step(v[8:5], v[4:1], v[0], 1'b1);
            check($sformatf("sweep a=%h b=%h cin=%b", v[8:5], v[4:1], v[0]), model(v[8:5], v[4:1], v[0]));
        end
        step(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("after sweep hold", {1'b0, model(4'b1111, 4'b1111, 1'b1)} & 11'b011_1111_1111);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
